regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised successor to the single-commit register file: architectural register values plus a per-register rename status (busy bit and ROB tag). It adds N read ports, W in-order commit ports, same-cycle commit-to-read bypass and a registered busy-register counter. It sits between the decoder (rename and operand lookup) and the ROB (commit and flush).

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers. Register 0 is hard-wired to zero.
- `XLEN`, 32: data width.
- `ROB_BITS`, 4: ROB tag width.
- `N_READ`, 4: read ports.
- `N_COMMIT`, 2: commit ports. Higher index is the younger instruction.
- `RID_BITS`, $clog2(NUM_REGS): register-index width.

Ports (vectors are packed, port k occupies slice k):
- `clk_in` in 1: clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rdy_in` in 1: when low, the block pauses and no state changes.
- `ren_en` in 1: rename request from the decoder.
- `ren_reg` in RID_BITS: destination register to rename.
- `ren_tag` in ROB_BITS: new ROB tag.
- `cm_en` in N_COMMIT: commit valid, per port.
- `cm_reg` in N_COMMIT*RID_BITS: commit destination register.
- `cm_tag` in N_COMMIT*ROB_BITS: committing ROB tag.
- `cm_val` in N_COMMIT*XLEN: commit value.
- `flush` in 1: ROB clear_all (mispredict).
- `rd_reg` in N_READ*RID_BITS: read addresses.
- `rd_busy` out N_READ: operand still pending.
- `rd_val` out N_READ*XLEN: operand value; 0 when busy.
- `rd_tag` out N_READ*ROB_BITS: producer tag; 0 when not busy.
- `busy_cnt` out RID_BITS+1: registered count of busy registers.

## Operation
- State per register r: `val[r]`, `busy[r]`, `tag[r]`. Register 0 is never written, renamed or busy.
- Reset (asynchronous, while `rst_n_in` = 0): all val, busy and tag bits are 0, and `busy_cnt` = 0.
- Commit, port k, when enabled and `cm_reg` != 0: write `val[cm_reg]` and clear `busy[cm_reg]` only if `tag[cm_reg]` == `cm_tag` and `busy[cm_reg]` = 1.
  - The value write is unconditional; only the busy clear is tag-gated.
- Two commit ports hitting the same register in one cycle: the highest enabled port wins both the value and the busy evaluation.
- Rename, when `ren_en` and `ren_reg` != 0: set `busy`=1 and `tag`=`ren_tag`. Rename overrides any commit busy-clear on the same register in the same cycle.
- Flush: all busy bits and tags become 0 and any rename that cycle is ignored. Commit value writes in the flush cycle still take effect.
- Reads are combinational, and each port is independent:
  - Base result: `busy[r]`, `val[r]` and `tag[r]`, with value and tag masked as described in the interface.
  - Bypass: if `busy[r]` and some enabled commit port writes r with tag == `tag[r]`, the port returns busy=0, value = that commit's `cm_val`, tag=0. When several ports match, the highest one is used.
  - Reads do not see a rename issued in the same cycle.
  - Register 0 always reads busy=0, value 0, tag 0.
- `busy_cnt` is the population count of the next-state busy vector, registered.

## Timing
- Reads: zero latency, combinational from `rd_reg` and the commit inputs.
- Writes, renames and flush: visible to reads one cycle after the clock edge (bypass excepted).
- `busy_cnt`: reflects the state after edge t in the cycle following t.
- `rdy_in` = 0: all state holds and inputs are ignored. Outputs still reflect the current state, and the bypass path remains active.
- Reset asserted mid-operation: state clears immediately, asynchronously. Deassertion is synchronised externally.

## Structure
- Package `regfile_pkg`: default `XLEN`, `NUM_REGS`, `ROB_BITS`; tag and register-index typedefs.
- Sub-module `regfile_rd_port`: one read port with the bypass priority mux, instantiated N_READ times via generate.
- Population count: implemented as a function inside `regfile_mp`.

## Test plan
- Reset, then read all 32 registers on 4 ports → busy=0, val=0, tag=0, busy_cnt=0.
- Rename x5→tag 3; next cycle commit x5 tag 3 val 0xDEAD → in the commit cycle, read of x5 returns busy=0, val 0xDEAD (bypass). After the edge: busy=0, busy_cnt=0.
- Rename x5→tag 3, then x5→tag 7; commit x5 tag 3 val 1 → val[x5]=1, busy=1, tag=7. Commit tag 7 val 2 → busy=0, val=2.
- Same cycle: commit port0 x9 tag 2 val 0xA and port1 x9 tag 4 val 0xB, with `tag[x9]`=4 → val=0xB, busy=0.
- Same cycle: commit x6 (matching tag) and rename x6→tag 9 → busy=1, tag=9, val updated.
- Rename x1..x4, then flush together with a commit of x2 val 0x55 and a rename of x8 → all busy 0, val[x2]=0x55, x8 not busy, busy_cnt=0. Writes or renames to x0 never change x0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and index/tag types for the multi-port
// register file.
//   DEF_NUM_REGS / DEF_XLEN / DEF_ROB_BITS : default geometry of regfile_mp
//   DEF_RID_BITS                           : register-index width for the defaults
//   rob_tag_t / reg_id_t                   : tag and register-index types at default widths
package regfile_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_ROB_BITS = 4;
  localparam int DEF_RID_BITS = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ROB_BITS-1:0] rob_tag_t;
  typedef logic [DEF_RID_BITS-1:0] reg_id_t;

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational operand-read port with commit bypass.
//   rd_reg                       : register being read
//   reg_busy / reg_val / reg_tag : stored state of that register
//   cm_en / cm_reg / cm_tag / cm_val : commit ports of the current cycle (packed, port k in slice k)
//   rd_busy / rd_val / rd_tag    : operand result; value masked to 0 while busy, tag masked to 0 while not busy
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int ROB_BITS = DEF_ROB_BITS,
  parameter int RID_BITS = DEF_RID_BITS,
  parameter int N_COMMIT = 2
) (
  input  logic [RID_BITS-1:0]          rd_reg,
  input  logic                         reg_busy,
  input  logic [XLEN-1:0]              reg_val,
  input  logic [ROB_BITS-1:0]          reg_tag,
  input  logic [N_COMMIT-1:0]          cm_en,
  input  logic [N_COMMIT*RID_BITS-1:0] cm_reg,
  input  logic [N_COMMIT*ROB_BITS-1:0] cm_tag,
  input  logic [N_COMMIT*XLEN-1:0]     cm_val,
  output logic                         rd_busy,
  output logic [XLEN-1:0]              rd_val,
  output logic [ROB_BITS-1:0]          rd_tag
);

  always_comb begin
    rd_busy = 1'b0;
    rd_val  = '0;
    rd_tag  = '0;
    if (rd_reg != '0) begin
      rd_busy = reg_busy;
      rd_val  = reg_busy ? '0 : reg_val;
      rd_tag  = reg_busy ? reg_tag : '0;
      // Ascending scan: a later (younger) matching commit overrides an
      // earlier one, so the highest matching port supplies the operand.
      for (int k = 0; k < N_COMMIT; k++) begin
        if (reg_busy && cm_en[k] &&
            (cm_reg[k*RID_BITS +: RID_BITS] == rd_reg) &&
            (cm_tag[k*ROB_BITS +: ROB_BITS] == reg_tag)) begin
          rd_busy = 1'b0;
          rd_val  = cm_val[k*XLEN +: XLEN];
          rd_tag  = '0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: architectural register file with rename status, N_READ
// combinational read ports, N_COMMIT in-order commit ports, commit-to-read
// bypass and a registered busy-register count.
//   clk_in, rst_n_in (async, active low)
//   rdy_in                     : global advance; low freezes all state
//   ren_en/ren_reg/ren_tag     : rename request from the decoder
//   cm_en/cm_reg/cm_tag/cm_val : commit ports (higher index = younger)
//   flush                      : clears every busy bit and tag
//   rd_reg -> rd_busy/rd_val/rd_tag : operand lookup, zero latency
//   busy_cnt                   : number of busy registers after the last edge
//
// Qualifier semantics: there is no back-pressure to the decoder or ROB.
// ren_en, cm_en[k] and flush are one-cycle request strobes that take effect
// at a rising edge only when rdy_in is high; with rdy_in low the strobes are
// ignored and nothing is stored, while reads (including bypass) stay live.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int XLEN     = DEF_XLEN,
  parameter int ROB_BITS = DEF_ROB_BITS,
  parameter int N_READ   = 4,
  parameter int N_COMMIT = 2,
  parameter int RID_BITS = $clog2(NUM_REGS)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         ren_en,
  input  logic [RID_BITS-1:0]          ren_reg,
  input  logic [ROB_BITS-1:0]          ren_tag,
  input  logic [N_COMMIT-1:0]          cm_en,
  input  logic [N_COMMIT*RID_BITS-1:0] cm_reg,
  input  logic [N_COMMIT*ROB_BITS-1:0] cm_tag,
  input  logic [N_COMMIT*XLEN-1:0]     cm_val,
  input  logic                         flush,
  input  logic [N_READ*RID_BITS-1:0]   rd_reg,
  output logic [N_READ-1:0]            rd_busy,
  output logic [N_READ*XLEN-1:0]       rd_val,
  output logic [N_READ*ROB_BITS-1:0]   rd_tag,
  output logic [RID_BITS:0]            busy_cnt
);

  logic [XLEN-1:0]     val_q [NUM_REGS];
  logic [ROB_BITS-1:0] tag_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;

  logic [XLEN-1:0]     val_d [NUM_REGS];
  logic [ROB_BITS-1:0] tag_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] clr;

  logic [RID_BITS-1:0] cm_reg_a [N_COMMIT];
  logic [ROB_BITS-1:0] cm_tag_a [N_COMMIT];
  logic [XLEN-1:0]     cm_val_a [N_COMMIT];

  function automatic logic [RID_BITS:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [RID_BITS:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + {{RID_BITS{1'b0}}, v[i]};
    end
    return n;
  endfunction

  for (genvar k = 0; k < N_COMMIT; k++) begin : g_cm
    assign cm_reg_a[k] = cm_reg[k*RID_BITS +: RID_BITS];
    assign cm_tag_a[k] = cm_tag[k*ROB_BITS +: ROB_BITS];
    assign cm_val_a[k] = cm_val[k*XLEN +: XLEN];
  end

  // Next-state: commits first (ascending, so the youngest port hitting a
  // register decides both its value and whether its busy bit clears), then
  // rename, then flush, which wipes rename status but keeps commit values.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    clr    = '0;
    for (int k = 0; k < N_COMMIT; k++) begin
      if (cm_en[k] && (cm_reg_a[k] != '0)) begin
        val_d[cm_reg_a[k]] = cm_val_a[k];
        clr[cm_reg_a[k]]   = busy_q[cm_reg_a[k]] && (tag_q[cm_reg_a[k]] == cm_tag_a[k]);
      end
    end
    busy_d = busy_q & ~clr;
    if (flush) begin
      busy_d = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_d[r] = '0;
      end
    end else if (ren_en && (ren_reg != '0)) begin
      busy_d[ren_reg] = 1'b1;
      tag_d[ren_reg]  = ren_tag;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q   <= '0;
      busy_cnt <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
    end else if (rdy_in) begin
      val_q    <= val_d;
      tag_q    <= tag_d;
      busy_q   <= busy_d;
      busy_cnt <= popcount(busy_d);
    end
  end

  for (genvar g = 0; g < N_READ; g++) begin : g_rd
    logic [RID_BITS-1:0] ra;
    assign ra = rd_reg[g*RID_BITS +: RID_BITS];

    regfile_rd_port #(
      .XLEN     (XLEN),
      .ROB_BITS (ROB_BITS),
      .RID_BITS (RID_BITS),
      .N_COMMIT (N_COMMIT)
    ) u_rd (
      .rd_reg   (ra),
      .reg_busy (busy_q[ra]),
      .reg_val  (val_q[ra]),
      .reg_tag  (tag_q[ra]),
      .cm_en    (cm_en),
      .cm_reg   (cm_reg),
      .cm_tag   (cm_tag),
      .cm_val   (cm_val),
      .rd_busy  (rd_busy[g]),
      .rd_val   (rd_val[g*XLEN +: XLEN]),
      .rd_tag   (rd_tag[g*ROB_BITS +: ROB_BITS])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. A behavioural model of the
// register file is checked against every read port and busy_cnt on each
// falling clock edge; hand-computed literals queued by the driver pin both
// the DUT and the model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int NR  = 32;
  localparam int XL  = 32;
  localparam int RB  = 4;
  localparam int NRD = 4;
  localparam int NC  = 2;
  localparam int IB  = 5;
  localparam int EW  = 40;  // {kind, port[1:0], busy, val[31:0], tag[3:0]}

  // ---------------- clock / reset ----------------
  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                 rdy_in = 1'b1;
  logic                 ren_en = 1'b0;
  reg_id_t              ren_reg = '0;
  rob_tag_t             ren_tag = '0;
  logic [NC-1:0]        cm_en  = '0;
  logic [NC*IB-1:0]     cm_reg = '0;
  logic [NC*RB-1:0]     cm_tag = '0;
  logic [NC*XL-1:0]     cm_val = '0;
  logic                 flush  = 1'b0;
  logic [NRD*IB-1:0]    rd_reg = '0;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*XL-1:0]    rd_val;
  logic [NRD*RB-1:0]    rd_tag;
  logic [IB:0]          busy_cnt;

  regfile_mp dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .ren_en   (ren_en),
    .ren_reg  (ren_reg),
    .ren_tag  (ren_tag),
    .cm_en    (cm_en),
    .cm_reg   (cm_reg),
    .cm_tag   (cm_tag),
    .cm_val   (cm_val),
    .flush    (flush),
    .rd_reg   (rd_reg),
    .rd_busy  (rd_busy),
    .rd_val   (rd_val),
    .rd_tag   (rd_tag),
    .busy_cnt (busy_cnt)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- behavioural model ----------------
  logic [XL-1:0] m_val [NR];
  logic [RB-1:0] m_tag [NR];
  logic [NR-1:0] m_busy;

  task automatic model_reset();
    m_busy = '0;
    for (int r = 0; r < NR; r++) begin
      m_val[r] = '0;
      m_tag[r] = '0;
    end
  endtask

  // Architectural view of one edge: each register listens to the youngest
  // commit naming it; a rename (unless flushed) marks it pending; a flush
  // forgets every pending producer.
  task automatic model_step();
    logic [XL-1:0] nv [NR];
    logic [RB-1:0] nt [NR];
    logic [NR-1:0] nb;
    nb = m_busy;
    for (int r = 0; r < NR; r++) begin
      nv[r] = m_val[r];
      nt[r] = m_tag[r];
    end
    for (int r = 1; r < NR; r++) begin
      for (int k = NC - 1; k >= 0; k--) begin
        if (cm_en[k] && int'(cm_reg[k*IB +: IB]) == r) begin
          nv[r] = cm_val[k*XL +: XL];
          if (m_busy[r] && m_tag[r] == cm_tag[k*RB +: RB]) nb[r] = 1'b0;
          break;
        end
      end
    end
    if (flush) begin
      nb = '0;
      for (int r = 0; r < NR; r++) nt[r] = '0;
    end else if (ren_en && ren_reg != '0) begin
      nb[ren_reg] = 1'b1;
      nt[ren_reg] = ren_tag;
    end
    m_busy = nb;
    for (int r = 0; r < NR; r++) begin
      m_val[r] = nv[r];
      m_tag[r] = nt[r];
    end
  endtask

  // Operand seen by a decoder reading register r right now.
  function automatic logic [XL+RB:0] model_read(input int r);
    logic b;
    logic [XL-1:0] v;
    logic [RB-1:0] t;
    if (r == 0) return '0;
    b = m_busy[r];
    v = b ? '0 : m_val[r];
    t = b ? m_tag[r] : '0;
    if (m_busy[r]) begin
      for (int k = NC - 1; k >= 0; k--) begin
        if (cm_en[k] && int'(cm_reg[k*IB +: IB]) == r && cm_tag[k*RB +: RB] == m_tag[r]) begin
          b = 1'b0;
          v = cm_val[k*XL +: XL];
          t = '0;
          break;
        end
      end
    end
    return {b, v, t};
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) model_reset();
    else if (rdy_in) model_step();
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [XL+RB:0] dut_read(input int p);
    return {rd_busy[p], rd_val[p*XL +: XL], rd_tag[p*RB +: RB]};
  endfunction

  always @(negedge clk_in) begin : cmp_proc
    logic [EW-1:0] e;
    int q;
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("port%0d x%0d vs model", p, rd_reg[p*IB +: IB]),
          64'(dut_read(p)), 64'(model_read(int'(rd_reg[p*IB +: IB]))));
    end
    chk("busy_cnt vs model", 64'(busy_cnt), 64'($countones(m_busy)));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[39]) begin
        chk("busy_cnt literal", 64'(busy_cnt), 64'(e[35:4]));
        chk("model busy_cnt literal", 64'($countones(m_busy)), 64'(e[35:4]));
      end else begin
        q = int'(e[38:37]);
        chk($sformatf("port%0d literal", q), 64'(dut_read(q)), 64'(e[36:0]));
        chk($sformatf("model port%0d literal", q),
            64'(model_read(int'(rd_reg[q*IB +: IB]))), 64'(e[36:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_cmds();
    ren_en = 1'b0;
    ren_reg = '0;
    ren_tag = '0;
    cm_en  = '0;
    cm_reg = '0;
    cm_tag = '0;
    cm_val = '0;
    flush  = 1'b0;
  endtask

  // Commands set since the last step are applied at the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    clear_cmds();
  endtask

  task automatic rename(input int r, input int t);
    ren_en  = 1'b1;
    ren_reg = 5'(r);
    ren_tag = 4'(t);
  endtask

  task automatic commit(input int k, input int r, input int t, input logic [XL-1:0] v);
    cm_en[k] = 1'b1;
    cm_reg[k*IB +: IB] = 5'(r);
    cm_tag[k*RB +: RB] = 4'(t);
    cm_val[k*XL +: XL] = v;
  endtask

  task automatic check_rd(input int p, input int r, input logic b, input logic [XL-1:0] v, input int t);
    rd_reg[p*IB +: IB] = 5'(r);
    exp_q.push_back({1'b0, 2'(p), b, v, 4'(t)});
  endtask

  task automatic check_cnt(input int c);
    exp_q.push_back({1'b1, 2'b00, 1'b0, 32'(c), 4'b0000});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    clear_cmds();
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;

    // Reset state of every register on all four ports.
    for (int base = 0; base < NR; base += NRD) begin
      for (int p = 0; p < NRD; p++) check_rd(p, base + p, 1'b0, 32'h0, 0);
      check_cnt(0);
      step();
    end

    // Rename then matching commit with same-cycle bypass.
    rename(5, 3); check_rd(0, 5, 1'b0, 32'h0, 0); check_cnt(0); step();
    commit(0, 5, 3, 32'hDEAD); check_rd(0, 5, 1'b0, 32'hDEAD, 0); check_cnt(1); step();
    check_rd(0, 5, 1'b0, 32'hDEAD, 0); check_cnt(0); rename(5, 3); step();

    // Stale commit writes the value but the newer rename keeps it busy.
    rename(5, 7); check_rd(0, 5, 1'b1, 32'h0, 3); check_cnt(1); step();
    commit(0, 5, 3, 32'h1); check_rd(0, 5, 1'b1, 32'h0, 7); check_cnt(1); step();
    commit(0, 5, 7, 32'h2); check_rd(0, 5, 1'b0, 32'h2, 0); check_cnt(1); step();
    check_rd(0, 5, 1'b0, 32'h2, 0); check_cnt(0); rename(9, 4); step();

    // Two ports on one register: youngest writer decides the stored state,
    // youngest tag match decides the bypass.
    commit(0, 9, 4, 32'hC); commit(1, 9, 2, 32'hD);
    check_rd(1, 9, 1'b0, 32'hC, 0); check_cnt(1); step();
    check_rd(1, 9, 1'b1, 32'h0, 4); check_cnt(1); step();
    commit(0, 9, 2, 32'hA); commit(1, 9, 4, 32'hB);
    check_rd(1, 9, 1'b0, 32'hB, 0); check_cnt(1); step();
    check_rd(1, 9, 1'b0, 32'hB, 0); check_cnt(0); rename(6, 1); step();

    // Commit and rename of the same register: rename wins the busy bit.
    commit(0, 6, 1, 32'h66); rename(6, 9);
    check_rd(2, 6, 1'b0, 32'h66, 0); check_cnt(1); step();
    check_rd(2, 6, 1'b1, 32'h0, 9); check_cnt(1); rename(1, 1); step();
    rename(2, 2); step();
    rename(3, 3); step();
    rename(4, 4); step();

    // Flush with a commit value write and an ignored rename.
    flush = 1'b1; commit(0, 2, 0, 32'h55); rename(8, 5);
    check_rd(3, 2, 1'b1, 32'h0, 2); check_cnt(5); step();
    check_rd(0, 2, 1'b0, 32'h55, 0); check_rd(1, 8, 1'b0, 32'h0, 0);
    check_rd(2, 6, 1'b0, 32'h66, 0); check_rd(3, 5, 1'b0, 32'h2, 0); check_cnt(0); step();

    // Register 0 ignores renames and commits.
    check_rd(0, 9, 1'b0, 32'hB, 0); check_rd(1, 1, 1'b0, 32'h0, 0);
    rename(0, 5); commit(1, 0, 0, 32'hFFFF);
    check_rd(2, 0, 1'b0, 32'h0, 0); check_cnt(0); step();
    check_rd(2, 0, 1'b0, 32'h0, 0); check_cnt(0); rename(10, 1); step();
    rename(11, 2); step();

    // Two commits to different registers in one cycle.
    commit(0, 10, 1, 32'h10); commit(1, 11, 2, 32'h11);
    check_rd(0, 10, 1'b0, 32'h10, 0); check_rd(1, 11, 1'b0, 32'h11, 0); check_cnt(2); step();
    check_rd(0, 10, 1'b0, 32'h10, 0); check_rd(1, 11, 1'b0, 32'h11, 0); check_cnt(0);
    rename(7, 3); step();

    // rdy_in low: state frozen, bypass still visible.
    rdy_in = 1'b0; commit(0, 7, 3, 32'h77); rename(12, 1);
    check_rd(0, 7, 1'b0, 32'h77, 0); check_rd(1, 12, 1'b0, 32'h0, 0); check_cnt(1); step();
    rdy_in = 1'b1;
    check_rd(0, 7, 1'b1, 32'h0, 3); check_rd(1, 12, 1'b0, 32'h0, 0); check_cnt(1); step();

    // Asynchronous reset mid-operation.
    rst_n_in = 1'b0;
    check_rd(0, 7, 1'b0, 32'h0, 0); check_rd(1, 5, 1'b0, 32'h0, 0);
    check_rd(2, 2, 1'b0, 32'h0, 0); check_cnt(0); step();
    rst_n_in = 1'b1;
    check_rd(0, 7, 1'b0, 32'h0, 0); check_rd(1, 5, 1'b0, 32'h0, 0); check_cnt(0); step();

    chk("literal queue drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
